// File: rtl/tv80_reg_dbg.sv
// Debug access port for the TV80 register file: borrows port A while the CPU
// is clock-gated to read, write or stream out register pairs.
module tv80_reg_dbg #(
  parameter int DUMP_LAST = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  // CPU side of register-file port A
  input  logic        cpu_cen,
  input  logic [2:0]  cpu_addra,
  input  logic [7:0]  cpu_dih,
  input  logic [7:0]  cpu_dil,
  input  logic        cpu_weh,
  input  logic        cpu_wel,
  // register-file port A
  output logic        rf_cen,
  output logic        rf_weh,
  output logic        rf_wel,
  output logic [2:0]  rf_addra,
  output logic [7:0]  rf_dih,
  output logic [7:0]  rf_dil,
  input  logic [7:0]  rf_doah,
  input  logic [7:0]  rf_doal,
  output logic        stall_req,
  // command interface
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [2:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic        dbg_busy,
  // read stream
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] dout_data,
  output logic [2:0]  dout_addr,
  output logic        dout_last
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    ACCESS,
    SEND,
    DONE
  } state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [2:0] LAST_A  = 3'(DUMP_LAST);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [15:0] dout_data_q, dout_data_d;
  logic [2:0]  dout_addr_q, dout_addr_d;
  logic        dout_last_q, dout_last_d;

  logic        wr_access;
  logic        handshake;

  assign wr_access = (state_q == ACCESS) && (op_q == OP_WR) && !cpu_cen;
  assign handshake = (state_q == SEND) && dout_ready;

  // Port A mux: the CPU always wins when it is clocked, whatever the state.
  always_comb begin
    rf_cen   = 1'b0;
    rf_weh   = 1'b0;
    rf_wel   = 1'b0;
    rf_addra = addr_q;
    rf_dih   = wdata_q[15:8];
    rf_dil   = wdata_q[7:0];
    if (cpu_cen) begin
      rf_cen   = 1'b1;
      rf_weh   = cpu_weh;
      rf_wel   = cpu_wel;
      rf_addra = cpu_addra;
      rf_dih   = cpu_dih;
      rf_dil   = cpu_dil;
    end else if (wr_access) begin
      rf_cen = 1'b1;
      rf_weh = 1'b1;
      rf_wel = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    dout_data_d = dout_data_q;
    dout_addr_d = dout_addr_q;
    dout_last_d = dout_last_q;
    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          op_d    = dbg_op;
          wdata_d = dbg_wdata;
          addr_d  = (dbg_op == OP_DUMP) ? 3'd0 : dbg_addr;
          if (dbg_op == 2'b11) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = WAIT_GRANT;
          end
        end
      end
      WAIT_GRANT: begin
        if (!cpu_cen) state_d = ACCESS;
      end
      ACCESS: begin
        // A grant lost here means nothing was touched; retry the same address.
        if (cpu_cen) begin
          state_d = WAIT_GRANT;
        end else if (op_q == OP_WR) begin
          state_d = DONE;
        end else begin
          dout_data_d = {rf_doah, rf_doal};
          dout_addr_d = addr_q;
          dout_last_d = (op_q == OP_RD) || (addr_q == LAST_A);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (dout_last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 3'd1;
            state_d = ACCESS;
          end
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      addr_q      <= 3'd0;
      wdata_q     <= 16'd0;
      err_q       <= 1'b0;
      dout_data_q <= 16'd0;
      dout_addr_q <= 3'd0;
      dout_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      dout_data_q <= dout_data_d;
      dout_addr_q <= dout_addr_d;
      dout_last_q <= dout_last_d;
    end
  end

  assign stall_req  = (state_q == WAIT_GRANT) || (state_q == ACCESS) || (state_q == SEND);
  assign dbg_busy   = (state_q != IDLE);
  assign dbg_ack    = (state_q == DONE);
  assign dbg_err    = (state_q == DONE) && err_q;
  assign dout_valid = (state_q == SEND);
  assign dout_data  = dout_data_q;
  assign dout_addr  = dout_addr_q;
  assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_tv80_reg_dbg.sv
// Directed bench for tv80_reg_dbg with a behavioural 8x16 register file.
module tb_tv80_reg_dbg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_cen;
  logic [2:0]  cpu_addra;
  logic [7:0]  cpu_dih, cpu_dil;
  logic        cpu_weh, cpu_wel;
  logic        rf_cen, rf_weh, rf_wel;
  logic [2:0]  rf_addra;
  logic [7:0]  rf_dih, rf_dil, rf_doah, rf_doal;
  logic        stall_req;
  logic        dbg_req;
  logic [1:0]  dbg_op;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack, dbg_err, dbg_busy;
  logic        dout_valid, dout_ready, dout_last;
  logic [15:0] dout_data;
  logic [2:0]  dout_addr;

  localparam logic [15:0] INIT [8] = '{16'h0F00, 16'h1234, 16'h2222, 16'h3333,
                                       16'h4444, 16'h5555, 16'h6666, 16'h7777};
  // pair 2 is overwritten with A55A before the dumps
  localparam logic [15:0] EXPD [8] = '{16'h0F00, 16'h1234, 16'hA55A, 16'h3333,
                                       16'h4444, 16'h5555, 16'h6666, 16'h7777};

  logic [15:0] mem [8];
  logic        preload;
  int          wr_cnt = 0;
  int          vecs = 0;
  int          errs = 0;
  int          w0;

  always #5 clk = ~clk;

  tv80_reg_dbg #(.DUMP_LAST(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_cen(cpu_cen), .cpu_addra(cpu_addra), .cpu_dih(cpu_dih), .cpu_dil(cpu_dil),
    .cpu_weh(cpu_weh), .cpu_wel(cpu_wel),
    .rf_cen(rf_cen), .rf_weh(rf_weh), .rf_wel(rf_wel), .rf_addra(rf_addra),
    .rf_dih(rf_dih), .rf_dil(rf_dil), .rf_doah(rf_doah), .rf_doal(rf_doal),
    .stall_req(stall_req),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_busy(dbg_busy),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_addr(dout_addr), .dout_last(dout_last)
  );

  assign rf_doah = mem[rf_addra][15:8];
  assign rf_doal = mem[rf_addra][7:0];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= INIT[i];
    end else if (rf_cen) begin
      if (rf_weh) mem[rf_addra][15:8] <= rf_dih;
      if (rf_wel) mem[rf_addra][7:0]  <= rf_dil;
      if (rf_weh || rf_wel) wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_stall"}, stall_req, 0);
    chk({tag, "_ack"},   dbg_ack, 0);
    chk({tag, "_err"},   dbg_err, 0);
    chk({tag, "_busy"},  dbg_busy, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_last"},  dout_last, 0);
    chk({tag, "_data"},  dout_data, 0);
    chk({tag, "_addr"},  dout_addr, 0);
  endtask

  initial begin
    reset_n = 0; preload = 1;
    cpu_cen = 1; cpu_addra = 3'd5; cpu_dih = 8'h9C; cpu_dil = 8'h3E; cpu_weh = 0; cpu_wel = 0;
    dbg_req = 0; dbg_op = 2'b00; dbg_addr = 3'd0; dbg_wdata = 16'h0; dout_ready = 0;
    tick; tick;

    // reset state and CPU pass-through
    chk_idle_outs("rst");
    chk("mir_cen", rf_cen, 1);
    chk("mir_addr", rf_addra, 5);
    chk("mir_dih", rf_dih, 8'h9C);
    chk("mir_dil", rf_dil, 8'h3E);
    cpu_wel = 1; #1;
    chk("mir_wel", rf_wel, 1);
    chk("mir_weh", rf_weh, 0);
    cpu_wel = 0; cpu_cen = 0; #1;
    chk("idle_cen", rf_cen, 0);
    chk("idle_we", {rf_weh, rf_wel}, 0);
    chk("idle_addr", rf_addra, 0);
    preload = 0; reset_n = 1;
    tick;

    // write pair 2
    w0 = wr_cnt;
    dbg_req = 1; dbg_op = 2'b01; dbg_addr = 3'd2; dbg_wdata = 16'hA55A;
    tick; dbg_req = 0;
    chk("wr_wg_stall", stall_req, 1);
    chk("wr_wg_busy", dbg_busy, 1);
    chk("wr_wg_cen", rf_cen, 0);
    tick;
    chk("wr_acc_cen", rf_cen, 1);
    chk("wr_acc_we", {rf_weh, rf_wel}, 2'b11);
    chk("wr_acc_addr", rf_addra, 2);
    chk("wr_acc_data", {rf_dih, rf_dil}, 16'hA55A);
    chk("wr_acc_ack", dbg_ack, 0);
    tick;
    chk("wr_ack", dbg_ack, 1);
    chk("wr_err", dbg_err, 0);
    chk("wr_done_stall", stall_req, 0);
    chk("wr_mem", mem[2], 16'hA55A);
    chk("wr_count", 16'(wr_cnt - w0), 1);
    tick;
    chk("wr_ack_end", dbg_ack, 0);
    chk("wr_idle_busy", dbg_busy, 0);

    // read pair 1
    dout_ready = 1;
    dbg_req = 1; dbg_op = 2'b00; dbg_addr = 3'd1;
    tick; dbg_req = 0;
    tick;
    chk("rd_acc_addr", rf_addra, 1);
    chk("rd_acc_cen", rf_cen, 0);
    tick;
    chk("rd_valid", dout_valid, 1);
    chk("rd_data", dout_data, 16'h1234);
    chk("rd_addr", dout_addr, 1);
    chk("rd_last", dout_last, 1);
    tick;
    chk("rd_ack", dbg_ack, 1);
    chk("rd_valid_end", dout_valid, 0);
    tick;

    // dump, ready held low for one cycle of every beat; dbg_addr ignored
    dout_ready = 0;
    dbg_req = 1; dbg_op = 2'b10; dbg_addr = 3'd5;
    tick; dbg_req = 0;
    tick;
    for (int a = 0; a < 8; a++) begin
      tick;
      chk("dmp_valid", dout_valid, 1);
      chk("dmp_addr", dout_addr, 16'(a));
      chk("dmp_data", dout_data, EXPD[a]);
      chk("dmp_last", dout_last, (a == 7) ? 1 : 0);
      tick;
      chk("dmp_hold_valid", dout_valid, 1);
      chk("dmp_hold_addr", dout_addr, 16'(a));
      chk("dmp_hold_data", dout_data, EXPD[a]);
      chk("dmp_stall", stall_req, 1);
      dout_ready = 1;
      tick;
      dout_ready = 0;
      chk("dmp_after_valid", dout_valid, 0);
      chk("dmp_after_ack", dbg_ack, (a == 7) ? 1 : 0);
    end
    tick;

    // CPU keeps the port for 5 cycles after a write request
    w0 = wr_cnt;
    cpu_cen = 1; cpu_weh = 0; cpu_wel = 0; cpu_addra = 3'd6;
    dbg_req = 1; dbg_op = 2'b01; dbg_addr = 3'd4; dbg_wdata = 16'hBEEF;
    tick; dbg_req = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_dih = 8'(8'h40 + i); cpu_dil = 8'(8'hC0 - i); #1;
      chk("stl_stall", stall_req, 1);
      chk("stl_cen", rf_cen, 1);
      chk("stl_addr", rf_addra, 6);
      chk("stl_data", {rf_dih, rf_dil}, {8'(8'h40 + i), 8'(8'hC0 - i)});
      chk("stl_we", {rf_weh, rf_wel}, 0);
      tick;
    end
    chk("stl_nowr", 16'(wr_cnt - w0), 0);
    cpu_cen = 0;
    tick;
    chk("stl_acc_data", {rf_dih, rf_dil}, 16'hBEEF);
    chk("stl_acc_addr", rf_addra, 4);
    tick;
    chk("stl_ack", dbg_ack, 1);
    chk("stl_mem", mem[4], 16'hBEEF);
    chk("stl_count", 16'(wr_cnt - w0), 1);
    tick;

    // dump with grant lost during ACCESS of pair 3, ready always high
    w0 = wr_cnt;
    dout_ready = 1;
    dbg_req = 1; dbg_op = 2'b10; dbg_addr = 3'd0;
    tick; dbg_req = 0;
    tick;
    for (int a = 0; a < 8; a++) begin
      if (a == 3) begin
        cpu_cen = 1; #1;
        chk("gl_mirror", rf_addra, cpu_addra);
        tick;
        chk("gl_wg_valid", dout_valid, 0);
        chk("gl_wg_stall", stall_req, 1);
        chk("gl_wg_addr", dout_addr, 2);
        tick;
        chk("gl_wg_hold", dout_valid, 0);
        cpu_cen = 0;
        tick;
        chk("gl_acc_addr", rf_addra, 3);
      end
      tick;
      chk("gl_valid", dout_valid, 1);
      chk("gl_addr", dout_addr, 16'(a));
      chk("gl_data", dout_data, EXPD[a] ^ ((a == 4) ? 16'hFAAB : 16'h0));
      chk("gl_last", dout_last, (a == 7) ? 1 : 0);
      tick;
    end
    chk("gl_ack", dbg_ack, 1);
    chk("gl_nowr", 16'(wr_cnt - w0), 0);
    tick;

    // reserved op
    dbg_req = 1; dbg_op = 2'b11; dbg_addr = 3'd1;
    tick; dbg_req = 0;
    chk("rsv_ack", dbg_ack, 1);
    chk("rsv_err", dbg_err, 1);
    chk("rsv_stall", stall_req, 0);
    tick;
    chk("rsv_ack_end", dbg_ack, 0);
    chk("rsv_err_end", dbg_err, 0);

    // reset while a read beat is waiting in SEND
    w0 = wr_cnt;
    dout_ready = 0;
    dbg_req = 1; dbg_op = 2'b00; dbg_addr = 3'd5;
    tick; dbg_req = 0;
    tick; tick;
    chk("rs_valid", dout_valid, 1);
    chk("rs_data", dout_data, 16'h5555);
    reset_n = 0; #1;
    chk_idle_outs("rs");
    chk("rs_rf_addr", rf_addra, 0);
    tick; tick;
    chk("rs_hold_ack", dbg_ack, 0);
    reset_n = 1;
    tick; tick;
    chk("rs_post_ack", dbg_ack, 0);
    chk("rs_post_busy", dbg_busy, 0);
    chk("rs_nowr", 16'(wr_cnt - w0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/tv80_reg_dbg.md
TV80_REG_DBG -- requirements
Module: tv80_reg_dbg

Interface
REQ-001 Parameter: DUMP_LAST, 7, highest register-pair address emitted by a dump (0..7).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_cen  in  1  CPU clock enable; 1 = CPU owns register-file port A.
REQ-005 cpu_addra  in  3  CPU port-A address.
REQ-006 cpu_dih, cpu_dil  in  8 each  CPU write data, high and low bytes.
REQ-007 cpu_weh, cpu_wel  in  1 each  CPU byte write enables.
REQ-008 rf_cen, rf_weh, rf_wel  out  1 each  to register file.
REQ-009 rf_addra  out  3  to register file.
REQ-010 rf_dih, rf_dil  out  8 each  to register file.
REQ-011 rf_doah, rf_doal  in  8 each  combinational port-A read data from register file.
REQ-012 stall_req  out  1  asks CPU to drop cpu_cen.
REQ-013 dbg_req  in  1  command request, level.
REQ-014 dbg_op  in  2  00 read pair, 01 write pair, 10 dump, 11 reserved.
REQ-015 dbg_addr  in  3 / dbg_wdata  in  16  command address / write data {H,L}.
REQ-016 dbg_ack, dbg_err  out  1 each  completion pulse / reserved-op flag (with ack).
REQ-017 dbg_busy  out  1  high in any state other than IDLE.
REQ-018 dout_valid  out  1 / dout_ready  in  1  read-stream handshake.
REQ-019 dout_data  out  16 / dout_addr  out  3 / dout_last  out  1  stream payload {H,L}, pair address, final beat.

Function
REQ-020 States SHALL be IDLE, WAIT_GRANT, ACCESS, SEND, DONE.
REQ-021 In IDLE, dbg_req=1 SHALL capture op/addr/wdata; next state WAIT_GRANT for ops 00/01/10; DONE with dbg_err=1 for op 11; dbg_req ignored outside IDLE.
REQ-022 Dump SHALL start at address 0 regardless of dbg_addr.
REQ-023 stall_req SHALL be 1 in WAIT_GRANT, ACCESS and SEND; 0 in IDLE and DONE.
REQ-024 WAIT_GRANT -> ACCESS when cpu_cen=0 in that cycle; else remain.
REQ-025 When cpu_cen=1, all rf_* outputs SHALL equal the cpu_* inputs combinationally (rf_cen=1), in every state.
REQ-026 When cpu_cen=0 and not in a write ACCESS: rf_cen=0, rf_weh=rf_wel=0, rf_addra=current sequencer address.
REQ-027 Write ACCESS with cpu_cen=0: rf_cen=1, rf_weh=rf_wel=1, rf_addra=captured addr, rf_dih/dil=wdata; exactly one cycle; next DONE.
REQ-028 Read/dump ACCESS with cpu_cen=0: register {rf_doah,rf_doal} and address into dout_data/dout_addr at cycle end; next SEND.
REQ-029 ACCESS with cpu_cen=1 (grant lost) SHALL perform no access and return to WAIT_GRANT.
REQ-030 SEND: dout_valid=1, payload stable until dout_valid&dout_ready; valid never drops without handshake.
REQ-031 dout_last=1 on a read beat and on the dump beat with address DUMP_LAST; 0 otherwise.
REQ-032 On handshake: if last, next DONE; else increment address, next ACCESS (ACCESS re-checks cpu_cen per REQ-029).
REQ-033 Handshake with dout_ready=1 on first SEND cycle SHALL cost no extra cycle; dump of N+1 pairs takes 2(N+1) cycles from first ACCESS under full grant and ready.
REQ-034 DONE: dbg_ack=1 for exactly one cycle, next IDLE; new dbg_req accepted in following IDLE cycle.
REQ-035 Address counter is 3 bits; no wrap past DUMP_LAST occurs.

Reset
REQ-036 reset_n=0 SHALL force state IDLE, address 0, and stall_req, dbg_ack, dbg_err, dbg_busy, dout_valid, dout_last, dout_data, dout_addr to 0 immediately; rf_* follow REQ-025/026.
REQ-037 Reset mid-operation SHALL abandon the command with no ack; no partial write occurs.

Verification
REQ-038 Write: req op01 addr2 wdata 0xA55A, cpu_cen=0 -> one rf write of H=0xA5 L=0x5A at addr 2, ack 2 cycles after WAIT_GRANT entry.
REQ-039 Read: pair1 preloaded 0x1234, ready=1 -> dout_data=0x1234, dout_addr=1, last=1, ack next cycle.
REQ-040 Dump with DUMP_LAST=7, ready toggling 1/0 -> 8 beats, addresses 0..7 in order, payload held while ready=0, last only on addr 7.
REQ-041 cpu_cen held 1 for 5 cycles after req -> stall_req high, no rf write, rf_* mirror cpu_* throughout; proceeds once cpu_cen=0.
REQ-042 cpu_cen rises in ACCESS of dump addr 3 -> return to WAIT_GRANT, addr 3 re-read after grant, no duplicated/skipped beat.
REQ-043 op11 -> ack and err pulse together, no stall_req; reset_n low during SEND -> all outputs 0, no ack.
